// File: rtl/controller_receiver_pkg.sv
// Shared definitions for the game-controller serial link: receiver state
// encoding, reply lengths and line timing at 27 MHz. The transmitter and its
// bench reuse the same constants so both sides agree on the bit format.
package controller_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_FALL   = 3'd1,
        ST_MEASURE_LOW = 3'd2,
        ST_WAIT_STOP   = 3'd3,
        ST_DONE        = 3'd4,
        ST_TIMEOUT     = 3'd5
    } rx_state_e;

    // Reply lengths in bits
    localparam int STATUS_BITS = 24;
    localparam int DATA_BITS   = 32;

    // Line timing in system clock cycles
    localparam int BIT_PERIOD_CYCLES = 108;
    localparam int THRESH_CYCLES     = 54;
    localparam int GLITCH_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES    = 4096;

    // Datapath widths
    localparam int WORD_W   = 32;
    localparam int CNT_W    = 13;
    localparam int BITCNT_W = 6;

    // Saturating increment for the low-phase and timeout counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/line_sync.sv
// Brings the asynchronous open-drain line into the clock domain with a
// two-flop synchronizer, then keeps one history flop for edge detection.
// The flops reset high because the idle line is high; this avoids a false
// fall right after reset.
module line_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic fall,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the pin through the synchronizer and history stage
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and history flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;
    assign rise = ~prev_q & sync_q;

endmodule

// File: rtl/controller_receiver.sv
// Receive-side deserializer for the controller link. Once armed, it measures
// the low phase of each bit (short low = '1', long low = '0'), shifts bits
// MSB-first into Data and raises OutValid after the stop-bit fall. A line
// that stays silent or stuck low for too long ends in Timeout instead.
module controller_receiver
    import controller_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = controller_receiver_pkg::TIMEOUT_CYCLES,
    parameter int THRESH_CYCLES  = controller_receiver_pkg::THRESH_CYCLES,
    parameter int GLITCH_CYCLES  = controller_receiver_pkg::GLITCH_CYCLES,
    parameter int STATUS_BITS    = controller_receiver_pkg::STATUS_BITS,
    parameter int DATA_BITS      = controller_receiver_pkg::DATA_BITS
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Rec_en,
    input  logic              Rec_Reset,
    input  logic              Rec_Status,
    input  logic              DataIn,
    output logic [WORD_W-1:0] Data,
    output logic              OutValid,
    output logic              Timeout
);

    localparam logic [CNT_W-1:0]    TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    THRESH_C = CNT_W'(THRESH_CYCLES);
    localparam logic [CNT_W-1:0]    GLITCH_C = CNT_W'(GLITCH_CYCLES);
    localparam logic [BITCNT_W-1:0] LEN_STAT = BITCNT_W'(STATUS_BITS);
    localparam logic [BITCNT_W-1:0] LEN_DATA = BITCNT_W'(DATA_BITS);

    rx_state_e state_q, state_d;

    logic [WORD_W-1:0]   data_q, data_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BITCNT_W-1:0] exp_len_q, exp_len_d;
    logic [CNT_W-1:0]    low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;

    logic line_s, line_fall, line_rise;
    logic to_expire, is_glitch, bit_val, last_bit;
    logic [BITCNT_W-1:0] bit_cnt_inc;

    line_sync u_line_sync (
        .clk  (Clock),
        .rst  (Reset),
        .din  (DataIn),
        .sync (line_s),
        .fall (line_fall),
        .rise (line_rise)
    );

    assign to_expire   = (to_cnt_q == TO_LAST);
    assign is_glitch   = (low_cnt_q < GLITCH_C);
    assign bit_val     = (low_cnt_q < THRESH_C);
    assign bit_cnt_inc = bit_cnt_q + 1'b1;
    assign last_bit    = (bit_cnt_inc == exp_len_q);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an edge always takes precedence over the timeout
    always_comb begin
        state_d = state_q;
        if (Rec_Reset || !Rec_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_FALL;
                end
                ST_WAIT_FALL: begin
                    if (line_fall) begin
                        state_d = ST_MEASURE_LOW;
                    end else if (to_expire) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_MEASURE_LOW: begin
                    if (line_rise) begin
                        if (!is_glitch && last_bit) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            state_d = ST_WAIT_FALL;
                        end
                    end else if (to_expire) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_WAIT_STOP: begin
                    if (line_fall) begin
                        state_d = ST_DONE;
                    end else if (to_expire) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Status flags follow the registered state only, so they are mutually exclusive
    always_comb begin
        OutValid = 1'b0;
        Timeout  = 1'b0;
        case (state_q)
            ST_DONE:    OutValid = 1'b1;
            ST_TIMEOUT: Timeout  = 1'b1;
            default: begin
                OutValid = 1'b0;
                Timeout  = 1'b0;
            end
        endcase
    end

    // Datapath next values: shift register, bit count and the two counters
    always_comb begin
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        exp_len_d = exp_len_q;
        low_cnt_d = low_cnt_q;
        to_cnt_d  = to_cnt_q;
        if (Rec_Reset) begin
            data_d    = '0;
            bit_cnt_d = '0;
            low_cnt_d = '0;
            to_cnt_d  = '0;
        end else if (Rec_en) begin
            case (state_q)
                ST_IDLE: begin
                    exp_len_d = Rec_Status ? LEN_STAT : LEN_DATA;
                    data_d    = '0;
                    bit_cnt_d = '0;
                    low_cnt_d = '0;
                    to_cnt_d  = '0;
                end
                ST_WAIT_FALL: begin
                    if (line_fall) begin
                        low_cnt_d = CNT_W'(1);
                        to_cnt_d  = '0;
                    end else begin
                        to_cnt_d = sat_inc(to_cnt_q);
                    end
                end
                ST_MEASURE_LOW: begin
                    if (line_rise) begin
                        to_cnt_d = '0;
                        if (!is_glitch) begin
                            data_d    = {data_q[WORD_W-2:0], bit_val};
                            bit_cnt_d = bit_cnt_inc;
                        end
                    end else begin
                        to_cnt_d = sat_inc(to_cnt_q);
                        if (!line_s) begin
                            low_cnt_d = sat_inc(low_cnt_q);
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    if (line_fall) begin
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = sat_inc(to_cnt_q);
                    end
                end
                default: begin
                    data_d = data_q;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            data_q    <= '0;
            bit_cnt_q <= '0;
            exp_len_q <= '0;
            low_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            exp_len_q <= exp_len_d;
            low_cnt_q <= low_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign Data = data_q;

endmodule

// File: tb/tb_controller_receiver.sv
// Directed bench for controller_receiver: status and button replies, silent
// and stuck-low timeouts, glitch rejection, abort, re-arm and async reset.
module tb_controller_receiver;

    logic        Clock;
    logic        Reset;
    logic        Rec_en;
    logic        Rec_Reset;
    logic        Rec_Status;
    logic        DataIn;
    logic [31:0] Data;
    logic        OutValid;
    logic        Timeout;

    int errors = 0;
    int checks = 0;

    controller_receiver dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Rec_en     (Rec_en),
        .Rec_Reset  (Rec_Reset),
        .Rec_Status (Rec_Status),
        .DataIn     (DataIn),
        .Data       (Data),
        .OutValid   (OutValid),
        .Timeout    (Timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // '1' = 27 low / 81 high, '0' = 81 low / 27 high
    task automatic send_bit(input logic b);
        DataIn = 1'b0;
        tick(b ? 27 : 81);
        DataIn = 1'b1;
        tick(b ? 81 : 27);
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        logic [31:0] v;
        v = w;
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    // Stop bit: fall, give the receiver 4 cycles, then finish the low phase
    task automatic send_stop();
        DataIn = 1'b0;
        tick(4);
    endtask

    task automatic end_stop();
        tick(23);
        DataIn = 1'b1;
        tick(5);
    endtask

    initial begin : stim
        int  n;
        logic saw_ov;

        Reset      = 1'b1;
        Rec_en     = 1'b0;
        Rec_Reset  = 1'b0;
        Rec_Status = 1'b0;
        DataIn     = 1'b1;
        tick(3);
        chk("reset_data", Data, 32'h0);
        chk("reset_valid", {31'b0, OutValid}, 32'h0);
        chk("reset_timeout", {31'b0, Timeout}, 32'h0);
        Reset = 1'b0;
        tick(3);

        // Status reply 0x050002
        Rec_Status = 1'b1;
        Rec_en     = 1'b1;
        tick(2);
        send_word(32'h0005_0002, 24);
        chk("status_pre_stop_valid", {31'b0, OutValid}, 32'h0);
        send_stop();
        chk("status_valid", {31'b0, OutValid}, 32'h1);
        chk("status_data", Data, 32'h0005_0002);
        chk("status_timeout", {31'b0, Timeout}, 32'h0);
        end_stop();
        Rec_en = 1'b0;
        tick(1);
        chk("status_drop_valid", {31'b0, OutValid}, 32'h0);
        chk("status_data_retained", Data, 32'h0005_0002);
        tick(2);

        // Button reply 0x80000001, held until Rec_en drops
        Rec_Status = 1'b0;
        Rec_en     = 1'b1;
        tick(2);
        send_word(32'h8000_0001, 32);
        send_stop();
        chk("button_valid", {31'b0, OutValid}, 32'h1);
        chk("button_data", Data, 32'h8000_0001);
        end_stop();
        send_bit(1'b0);
        tick(40);
        chk("button_hold_valid", {31'b0, OutValid}, 32'h1);
        chk("button_hold_data", Data, 32'h8000_0001);
        Rec_en = 1'b0;
        tick(1);
        chk("button_drop_valid", {31'b0, OutValid}, 32'h0);
        tick(2);

        // Silent line: Timeout exactly 4096 cycles after the arming edge
        Rec_en = 1'b1;
        tick(4096);
        chk("silent_not_yet", {31'b0, Timeout}, 32'h0);
        chk("silent_data_cleared", Data, 32'h0);
        tick(1);
        chk("silent_timeout", {31'b0, Timeout}, 32'h1);
        chk("silent_no_valid", {31'b0, OutValid}, 32'h0);
        Rec_Reset = 1'b1;
        tick(1);
        chk("silent_rr_timeout", {31'b0, Timeout}, 32'h0);
        chk("silent_rr_data", Data, 32'h0);
        Rec_Reset = 1'b0;
        Rec_en    = 1'b0;
        tick(2);

        // Stuck low after 5 bits (10110)
        Rec_Status = 1'b0;
        Rec_en     = 1'b1;
        tick(2);
        send_word(32'h0000_0016, 5);
        DataIn = 1'b0;
        n = 0;
        saw_ov = 1'b0;
        while (!Timeout && n < 4300) begin
            tick(1);
            n++;
            if (OutValid) saw_ov = 1'b1;
        end
        chk("stuck_latency", 32'(n), 32'd4099);
        chk("stuck_timeout", {31'b0, Timeout}, 32'h1);
        chk("stuck_no_valid", {31'b0, saw_ov}, 32'h0);
        chk("stuck_partial_data", Data, 32'h0000_0016);
        Rec_en = 1'b0;
        DataIn = 1'b1;
        tick(3);
        chk("stuck_drop_timeout", {31'b0, Timeout}, 32'h0);

        // Glitch between bits 3 and 4 of 0xFFFFFF
        Rec_Status = 1'b1;
        Rec_en     = 1'b1;
        tick(2);
        for (int i = 0; i < 24; i++) begin
            send_bit(1'b1);
            if (i == 2) begin
                DataIn = 1'b0;
                tick(2);
                DataIn = 1'b1;
                tick(20);
            end
        end
        send_stop();
        chk("glitch_valid", {31'b0, OutValid}, 32'h1);
        chk("glitch_data", Data, 32'h00FF_FFFF);
        end_stop();
        Rec_en = 1'b0;
        tick(2);

        // Abort after 10 bits
        Rec_Status = 1'b0;
        Rec_en     = 1'b1;
        tick(2);
        send_word(32'h0000_02AA, 10);
        Rec_en = 1'b0;
        tick(1);
        chk("abort_valid", {31'b0, OutValid}, 32'h0);
        chk("abort_timeout", {31'b0, Timeout}, 32'h0);
        tick(5);
        chk("abort_idle_valid", {31'b0, OutValid}, 32'h0);
        chk("abort_data_retained", Data, 32'h0000_02AA);

        // Re-arm and receive 0x123456, leave DONE via Rec_Reset
        Rec_Status = 1'b1;
        Rec_en     = 1'b1;
        tick(2);
        send_word(32'h0012_3456, 24);
        send_stop();
        chk("rearm_valid", {31'b0, OutValid}, 32'h1);
        chk("rearm_data", Data, 32'h0012_3456);
        end_stop();
        Rec_Reset = 1'b1;
        tick(1);
        chk("rearm_rr_valid", {31'b0, OutValid}, 32'h0);
        chk("rearm_rr_data", Data, 32'h0);
        Rec_Reset = 1'b0;
        Rec_en    = 1'b0;
        tick(2);

        // Async reset in the middle of a bit
        Rec_Status = 1'b0;
        Rec_en     = 1'b1;
        tick(2);
        send_word(32'h0000_0005, 3);
        DataIn = 1'b0;
        tick(10);
        chk("midbit_data_before", Data, 32'h0000_0005);
        Reset = 1'b1;
        #1;
        chk("midbit_reset_data", Data, 32'h0);
        chk("midbit_reset_valid", {31'b0, OutValid}, 32'h0);
        chk("midbit_reset_timeout", {31'b0, Timeout}, 32'h0);
        Rec_en = 1'b0;
        DataIn = 1'b1;
        tick(2);
        Reset = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controller_receiver.md
Name: controller_receiver

Overview:
- Receive-side deserializer for the game-controller serial link; sits directly downstream of the line and upstream of the control FSM.
- When armed by the FSM, it decodes pulse-width-encoded bits from the synchronized data pin and shifts them into a word.
- On a complete reply it raises OutValid. If the line stays idle or stuck too long, it raises Timeout.
- Both flags are consumed by the control FSM to sequence reset/status/get transactions.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles without a line edge before Timeout is declared.
- THRESH_CYCLES, 54: low-phase length (2 us at 27 MHz) separating a '1' (shorter) from a '0' (equal or longer).
- GLITCH_CYCLES, 4: low pulses shorter than this are ignored.
- STATUS_BITS, 24: reply length when Rec_Status=1.
- DATA_BITS, 32: reply length when Rec_Status=0.

Ports:
- Clock  in  1  system clock, 27 MHz.
- Reset  in  1  asynchronous, active-high; clears all state.
- Rec_en  in  1  level from control FSM; high = armed/receiving.
- Rec_Reset  in  1  synchronous clear from control FSM; returns to IDLE.
- Rec_Status  in  1  sampled at arm; 1 = expect STATUS_BITS, 0 = expect DATA_BITS.
- DataIn  in  1  raw open-drain line, idle high, asynchronous.
- Data  out  32  received word, right-aligned, MSB received first; unused upper bits 0.
- OutValid  out  1  level; reply complete, Data stable.
- Timeout  out  1  level; reception failed.

Behaviour:
- Reset values: Data=0, OutValid=0, Timeout=0, state=IDLE, all counters 0.
- Input path: two-flop synchronizer, then one history register.
  - fall = prev & ~sync; rise = ~prev & sync.
  - Pin-to-decision latency is 3 cycles.
- States: IDLE, WAIT_FALL, MEASURE_LOW, WAIT_STOP, DONE, TIMEOUT.
- IDLE:
  - Rec_en=1 -> WAIT_FALL.
  - On arm: latch Rec_Status into an expected-length register, clear Data, clear bit counter, clear timeout counter.
- WAIT_FALL:
  - fall -> MEASURE_LOW, low counter=1.
  - Otherwise timeout counter increments.
- MEASURE_LOW:
  - Low counter increments while sync=0.
  - On rise with low counter < GLITCH_CYCLES: treat as glitch, return to WAIT_FALL, no bit recorded.
  - On rise otherwise: bit = (low counter < THRESH_CYCLES); shift into Data LSB; bit counter+1.
  - After the shift, bit counter == expected length -> WAIT_STOP; else -> WAIT_FALL.
  - Timeout counter is cleared on every accepted edge.
- WAIT_STOP:
  - fall (stop bit) -> DONE. OutValid=1 on the cycle after fall is detected.
  - Stop-bit width is not checked.
- DONE:
  - Hold OutValid=1 and Data until Rec_en=0 or Rec_Reset=1, then -> IDLE.
  - Ignore further line activity.
- Timeout:
  - In WAIT_FALL, MEASURE_LOW or WAIT_STOP, timeout counter reaching TIMEOUT_CYCLES-1 -> TIMEOUT.
  - Timeout=1 on the next cycle. This covers both a stuck-low and a silent line.
- TIMEOUT: hold Timeout=1 until Rec_en=0 or Rec_Reset=1, then -> IDLE.
- Rec_en=0 in any state: -> IDLE next cycle. OutValid and Timeout clear, Data retained.
- Rec_Reset=1: highest priority after Reset. -> IDLE, OutValid=0, Timeout=0, Data=0.
- OutValid and Timeout are never both 1.
- Counters: low counter and timeout counter are 13 bits and saturate; they never wrap.
- Arming with Rec_en=1 while DataIn is already low: no fall is seen. The receiver waits for the line to go high then fall again, or times out.
- Simultaneous fall and timeout terminal count in the same cycle: the edge wins and the counter clears.

Decomposition:
- Shared package holds:
  - the state encoding;
  - bit-length constants: STATUS_BITS, DATA_BITS;
  - timing constants: THRESH_CYCLES, GLITCH_CYCLES, TIMEOUT_CYCLES, plus the nominal bit period of 108 cycles.
- These constants are reused by the transmitter and its bench.
- One sub-module: line_sync (two-flop synchronizer plus edge detect; outputs sync, fall, rise).

Test Plan:
- Bit encoding for all scenarios, 108-cycle bits: '1' = 27 low / 81 high; '0' = 81 low / 27 high.
- Status reply: Rec_Status=1, drive 0x050002 + stop -> OutValid=1 within 4 cycles of stop fall, Data=0x00050002, Timeout=0.
- Button reply: Rec_Status=0, drive 0x8000_0001 + stop -> Data=0x80000001, OutValid held until Rec_en=0, then OutValid=0 next cycle.
- Silent line: arm and hold DataIn=1 for 4100 cycles -> Timeout=1 exactly 4096 cycles (+1) after arm, OutValid=0. Rec_Reset clears Timeout and Data.
- Stuck low: after 5 valid bits, hold DataIn=0 -> Timeout after 4096 cycles, no OutValid.
- Glitch: insert a 2-cycle low pulse between bits 3 and 4 of 0xFFFFFF -> Data=0x00FFFFFF, bit count unaffected.
- Aborts:
  - Drop Rec_en after 10 bits -> IDLE, no flags.
  - Re-arm and receive 0x123456 -> correct.
  - Assert Reset mid-bit -> all outputs 0 immediately.
